ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port data RAM, which has a combinational read and a clocked byte-enabled write. The CPU data port (master 0) and the debug/DMA port (master 1) share the RAM. The arbiter grants one master per transaction with round-robin fairness, drives the RAM's ce/we/addr/sel/data pins for exactly one access cycle, registers the read data, and returns a one-cycle ack.

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arbiter
//  Description : Round-robin arbiter and access sequencer placing two
//                requesters (CPU data port, debug/DMA port) in front of a
//                single-port RAM with combinational read and byte-enabled
//                clocked write. One RAM access cycle per transaction,
//                registered read data and a one-cycle ack per master.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic [DATA_W-1:0]   m0_wdata,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic [DATA_W-1:0]   m1_wdata,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic                ram_ce,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_sel,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,

    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_grant;
    logic                w_grant_next;
    logic                r_last;
    logic                w_last_next;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                w_granted_we;

    // Granted master's write flag; selects read-capture vs. write commit.
    assign w_granted_we = r_grant ? m1_we : m0_we;

    // State, grant and last-granted registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;   // master 0 wins the first tie after reset
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_last  <= w_last_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, one access cycle, one ack cycle.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_last_next  = r_last;
        case (r_state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    w_state_next = S_ACCESS;
                    if (m0_req && m1_req) begin
                        w_grant_next = ~r_last;
                    end else begin
                        w_grant_next = m1_req;
                    end
                end
            end
            S_ACCESS: begin
                w_last_next  = r_grant;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // RAM pins: driven from the granted master only during ACCESS. ce/we are
    // gated with rst so a reset landing on the access edge aborts the write.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_sel   = '0;
        ram_wdata = '0;
        if (r_state == S_ACCESS) begin
            ram_ce    = ~rst;
            ram_we    = ~rst & w_granted_we;
            ram_addr  = r_grant ? m1_addr  : m0_addr;
            ram_sel   = r_grant ? m1_sel   : m0_sel;
            ram_wdata = r_grant ? m1_wdata : m0_wdata;
        end
    end

    // Read-data capture at the closing edge of a read access; writes and the
    // non-granted master leave their registers untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else if (r_state == S_ACCESS && !w_granted_we) begin
            if (r_grant) begin
                r_m1_rdata <= ram_rdata;
            end else begin
                r_m0_rdata <= ram_rdata;
            end
        end
    end

    assign m0_ack   = (r_state == S_RESP) && !r_grant;
    assign m1_ack   = (r_state == S_RESP) &&  r_grant;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_arbiter
//  Description : Self-checking bench for ram_arbiter with a behavioural RAM
//                and a transaction-level arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        busy;

    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Combinational RAM read port.
    assign ram_rdata = mem[ram_addr[7:2]];

    ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    // One clock: the RAM's clocked write is applied with the pin values seen
    // before the edge, then outputs are sampled 1 time unit later.
    task automatic tick();
        logic        wr;
        logic [5:0]  idx;
        logic [3:0]  sel;
        logic [31:0] wd;
        wr  = ram_ce && ram_we;
        idx = ram_addr[7:2];
        sel = ram_sel;
        wd  = ram_wdata;
        @(posedge clk);
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        #1;
    endtask

    task automatic idle_masters();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_sel = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_sel = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_masters();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({m0_ack, m1_ack} !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", {m0_ack, m1_ack}); end
        checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h %h want 0 0", m0_rdata, m1_rdata); end
        checks++; if ({ram_ce, ram_we, ram_addr, ram_sel, ram_wdata} !== '0) begin errors++; $display("FAIL reset_ram_pins got ce=%b we=%b addr=%h sel=%h wd=%h want all 0", ram_ce, ram_we, ram_addr, ram_sel, ram_wdata); end
    endtask

    task automatic test_single_read();
        mem[6'h04] = 32'hDEADBEEF;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        tick();
        checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h10) begin errors++; $display("FAIL read_access got ce=%b we=%b addr=%h want 1 0 10", ram_ce, ram_we, ram_addr); end
        checks++; if (m0_ack !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_access_ack got ack=%b busy=%b want 0 1", m0_ack, busy); end
        tick();
        checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin errors++; $display("FAIL read_ack got %b%b want 10", m0_ack, m1_ack); end
        checks++; if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data got %h want deadbeef", m0_rdata); end
        checks++; if (ram_ce !== 1'b0) begin errors++; $display("FAIL read_ce_one_cycle got %b want 0", ram_ce); end
        m0_req = 0;
        tick();
        checks++; if (m0_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL read_after got ack=%b busy=%b want 0 0", m0_ack, busy); end
    endtask

    task automatic test_byte_write();
        mem[6'h08] = 32'h11223344;
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'b0101; m1_wdata = 32'hAABBCCDD;
        tick();
        checks++; if (ram_we !== 1'b1 || ram_sel !== 4'b0101 || ram_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL write_pins got we=%b sel=%b wd=%h want 1 0101 aabbccdd", ram_we, ram_sel, ram_wdata); end
        tick();
        checks++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin errors++; $display("FAIL write_ack got %b%b want 01", m0_ack, m1_ack); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL write_rdata_hold got %h want 0", m1_rdata); end
        m1_req = 0; m1_we = 0; m1_sel = 0;
        tick();
        checks++; if (mem[6'h08] !== 32'h11BB33DD) begin errors++; $display("FAIL write_ram got %h want 11bb33dd", mem[6'h08]); end
        m1_req = 1;
        tick();
        tick();
        checks++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h11BB33DD) begin errors++; $display("FAIL write_readback got ack=%b data=%h want 1 11bb33dd", m1_ack, m1_rdata); end
        m1_req = 0;
        tick();
    endtask

    task automatic test_contention();
        int n_ack;
        do_reset();
        mem[16] = 32'hA0A0A0A0;
        mem[17] = 32'hB1B1B1B1;
        m0_req = 1; m0_addr = 32'h40;
        m1_req = 1; m1_addr = 32'h44;
        n_ack = 0;
        for (int c = 1; c <= 18; c++) begin
            logic e0, e1;
            tick();
            e0 = (c % 3 == 2) && (((c - 2) / 3) % 2 == 0);
            e1 = (c % 3 == 2) && (((c - 2) / 3) % 2 == 1);
            checks++; if (m0_ack !== e0 || m1_ack !== e1) begin errors++; $display("FAIL contention_ack c=%0d got %b%b want %b%b", c, m0_ack, m1_ack, e0, e1); end
            if (e0) begin checks++; if (m0_rdata !== 32'hA0A0A0A0) begin errors++; $display("FAIL contention_m0_data got %h want a0a0a0a0", m0_rdata); end end
            if (e1) begin checks++; if (m1_rdata !== 32'hB1B1B1B1) begin errors++; $display("FAIL contention_m1_data got %h want b1b1b1b1", m1_rdata); end end
            if (m0_ack || m1_ack) n_ack++;
        end
        checks++; if (n_ack != 6) begin errors++; $display("FAIL contention_count got %0d want 6", n_ack); end
        idle_masters();
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [4];
        for (int k = 0; k < 4; k++) begin
            exp[k] = $urandom;
            mem[k] = exp[k];
        end
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            logic e;
            int   k;
            tick();
            e = (c % 3 == 2);
            k = (c - 2) / 3;
            checks++; if (m0_ack !== e || m1_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack c=%0d got %b%b want %b0", c, m0_ack, m1_ack, e); end
            if (e) begin
                checks++; if (m0_rdata !== exp[k]) begin errors++; $display("FAIL b2b_data k=%0d got %h want %h", k, m0_rdata, exp[k]); end
                if (k < 3) m0_addr = 32'(4 * (k + 1));
                else m0_req = 0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        mem[12] = 32'h0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_sel = 4'hF; m0_wdata = 32'h55555555;
        tick();
        checks++; if (ram_ce !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL abort_access got ce=%b we=%b want 1 1", ram_ce, ram_we); end
        rst = 1;
        #1;
        checks++; if (ram_ce !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL abort_gate got ce=%b we=%b want 0 0", ram_ce, ram_we); end
        m0_req = 0;
        tick();
        checks++; if ({m0_ack, m1_ack, busy, ram_ce, ram_we, ram_addr, ram_sel, ram_wdata, m0_rdata, m1_rdata} !== '0) begin errors++; $display("FAIL abort_outputs got ack=%b%b busy=%b ce=%b addr=%h rd=%h %h want all 0", m0_ack, m1_ack, busy, ram_ce, ram_addr, m0_rdata, m1_rdata); end
        checks++; if (mem[12] !== 32'h0) begin errors++; $display("FAIL abort_ram got %h want 0", mem[12]); end
        rst = 0;
        idle_masters();
        tick();
        checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b want 0", m0_ack); end
    endtask

    task automatic test_idle();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if ({busy, ram_ce, m0_ack, m1_ack} !== 4'b0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL idle c=%0d got busy=%b ce=%b ack=%b%b rd=%h %h want all 0", c, busy, ram_ce, m0_ack, m1_ack, m0_rdata, m1_rdata); end
        end
    endtask

    // Randomised traffic against a transaction-level model: a free slot every
    // third edge after a grant, round-robin on ties, shadow memory for data.
    task automatic test_random();
        logic [31:0] ref_mem [0:15];
        logic [31:0] exp_rd [2];
        int  n, free_edge, ack_cycle, ack_m;
        bit  ack_valid, mlast;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            ref_mem[k] = $urandom;
            mem[k] = ref_mem[k];
        end
        exp_rd[0] = 0; exp_rd[1] = 0;
        n = 0; free_edge = 0; ack_cycle = 0; ack_m = 0; ack_valid = 0; mlast = 1;
        for (int it = 0; it < 400; it++) begin
            if (!m0_req && $urandom_range(0, 2) == 0) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = 32'($urandom_range(0, 15)) << 2;
                m0_sel = 4'($urandom); m0_wdata = $urandom;
            end
            if (!m1_req && $urandom_range(0, 2) == 0) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = 32'($urandom_range(0, 15)) << 2;
                m1_sel = 4'($urandom); m1_wdata = $urandom;
            end
            n++;
            if (n >= free_edge && (m0_req || m1_req)) begin
                int          w;
                logic        we;
                logic [3:0]  idx, sel;
                logic [31:0] wd;
                w   = (m0_req && m1_req) ? int'(!mlast) : (m1_req ? 1 : 0);
                we  = w ? m1_we : m0_we;
                idx = w ? m1_addr[5:2] : m0_addr[5:2];
                sel = w ? m1_sel : m0_sel;
                wd  = w ? m1_wdata : m0_wdata;
                if (we) begin
                    for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    exp_rd[w] = ref_mem[idx];
                end
                mlast = (w == 1);
                ack_valid = 1; ack_cycle = n + 1; ack_m = w; free_edge = n + 3;
            end
            tick();
            begin
                logic e0, e1;
                e0 = ack_valid && ack_cycle == n && ack_m == 0;
                e1 = ack_valid && ack_cycle == n && ack_m == 1;
                checks++; if (m0_ack !== e0 || m1_ack !== e1) begin errors++; $display("FAIL rand_ack n=%0d got %b%b want %b%b", n, m0_ack, m1_ack, e0, e1); end
                if (e0) begin checks++; if (m0_rdata !== exp_rd[0]) begin errors++; $display("FAIL rand_m0_data n=%0d got %h want %h", n, m0_rdata, exp_rd[0]); end end
                if (e1) begin checks++; if (m1_rdata !== exp_rd[1]) begin errors++; $display("FAIL rand_m1_data n=%0d got %h want %h", n, m1_rdata, exp_rd[1]); end end
            end
            if (m0_ack) m0_req = 0;
            if (m1_ack) m1_req = 0;
        end
        idle_masters();
        tick(); tick(); tick();
        for (int k = 0; k < 16; k++) begin
            checks++; if (mem[k] !== ref_mem[k]) begin errors++; $display("FAIL rand_mem word=%0d got %h want %h", k, mem[k], ref_mem[k]); end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'h0;
        rst = 1;
        idle_masters();
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_back_to_back();
        test_reset_mid_access();
        test_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
